// File: rtl/weight_sram_pkg.sv
// Shared widths and types for the weight SRAM controller: FSM states and the
// output FIFO entry (data word plus burst-last tag).
package weight_sram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/weight_out_fifo.sv
// Synchronous output FIFO of DEPTH entries (any DEPTH >= 2, not only powers
// of two); exposes the head entry and the current occupancy.
module weight_out_fifo
  import weight_sram_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              push,
  input  fifo_entry_t       push_entry,
  input  logic              pop,
  output fifo_entry_t       head,
  output logic [CNT_W-1:0]  count
);

  fifo_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone define which entries are valid, so stale contents are never seen.
  always_ff @(posedge CK) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM controller: single-word writes plus burst reads streamed over
// valid/ready. Optional counters under `WEIGHT_SRAM_CTRL_STATS_EN.
module weight_sram_ctrl #(
  parameter int ADDR_W     = weight_sram_pkg::ADDR_W,
  parameter int DATA_W     = weight_sram_pkg::DATA_W,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              busy,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic              SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DI,
  input  logic [DATA_W-1:0] SRAM_DO
`ifdef WEIGHT_SRAM_CTRL_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
`endif
);

  import weight_sram_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain;
  logic              inflight, inflight_last;
  logic [CNT_W-1:0]  fifo_count;
  fifo_entry_t       head, push_entry;
  logic              issue, wr_fire, pop, credit;

  // A read may issue only if the FIFO still has room for it and any read in flight.
  assign credit  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign wr_fire = wr_valid && wr_ready;
  assign pop     = w_valid && w_ready;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !RST;
        wr_ready  = !RST && !cmd_valid;
        if (cmd_valid && cmd_len != '0) state_nx = READ;
      end
      READ: begin
        issue = credit && (remain != '0);
        if (issue && remain == (ADDR_W+1)'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!inflight && (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      addr_q        <= '0;
      remain        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (cmd_valid && cmd_ready) begin
        addr_q <= cmd_base;
        remain <= cmd_len;
      end else if (issue) begin
        addr_q        <= addr_q + 1'b1;
        remain        <= remain - 1'b1;
        inflight_last <= (remain == (ADDR_W+1)'(1));
      end
    end
  end

  assign SRAM_CS  = issue || wr_fire;
  assign SRAM_WEB = !wr_fire;
  assign SRAM_OE  = (state != IDLE);
  assign SRAM_A   = issue ? addr_q : (wr_fire ? wr_addr : '0);
  assign SRAM_DI  = wr_fire ? wr_data : '0;
  assign busy     = (state != IDLE);

  // Read data arrives the cycle after issue and is captured at the next edge.
  assign push_entry = '{last: inflight_last, data: SRAM_DO};

  weight_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CK         (CK),
    .RST        (RST),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  assign w_valid = (fifo_count != '0);
  assign w_data  = w_valid ? head.data : '0;
  assign w_last  = w_valid && head.last;

`ifdef WEIGHT_SRAM_CTRL_STATS_EN
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (stat_clr) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (issue   && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 1'b1;
      if (wr_fire && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Directed bench for weight_sram_ctrl with a behavioural 256x32 SRAM model.
module tb_weight_sram_ctrl;

  localparam int FIFO_DEPTH = 3;

  logic        CK = 1'b0;
  logic        RST;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_base;
  logic [8:0]  cmd_len;
  logic        w_valid, w_ready, w_last, busy;
  logic [31:0] w_data;
  logic        SRAM_CS, SRAM_OE, SRAM_WEB;
  logic [7:0]  SRAM_A;
  logic [31:0] SRAM_DI, SRAM_DO;
`ifdef WEIGHT_SRAM_CTRL_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

  logic [31:0] sram_mem [256];
  logic [31:0] exp_mem  [256];
  int n_asserts = 0;
  int n_fail    = 0;

  weight_sram_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) u_dut (
    .CK(CK), .RST(RST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last), .busy(busy),
    .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
`ifdef WEIGHT_SRAM_CTRL_STATS_EN
    , .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (SRAM_CS) begin
      if (!SRAM_WEB) sram_mem[SRAM_A] <= SRAM_DI;
      else           SRAM_DO <= sram_mem[SRAM_A];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic start_cmd(input int base, input int len);
    cmd_base  = 8'(base);
    cmd_len   = 9'(len);
    cmd_valid = 1'b1;
    #1;
    check("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Entered one cycle after command accept; cyc counts cycles since accept.
  task automatic collect(input int base, input int len, input bit toggle, input int exp_cycle);
    int k, cyc, max_cnt;
    bit stalled, gap;
    logic [31:0] held;
    k = 0; cyc = 1; max_cnt = 0; stalled = 0; gap = 0; held = '0;
    while (k < len && cyc < 600) begin
      w_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
      if (w_valid) begin
        if (stalled) check("hold_stable", w_data, held);
        check("data", w_data, exp_mem[(base + k) % 256]);
        check("last", w_last, k == len - 1);
        if (w_ready && k == len - 1 && exp_cycle >= 0) check("last_cycle", cyc, exp_cycle);
        stalled = !w_ready;
        held    = w_data;
        if (w_ready) k++;
      end else if (k > 0 && !toggle) begin
        gap = 1'b1;
      end
      @(posedge CK);
      #1;
      cyc++;
    end
    check("word_count", k, len);
    check("no_gap", gap, 0);
    check("fifo_bound", max_cnt <= FIFO_DEPTH, 1);
    check("idle_after", busy, 0);
    check("no_extra", w_valid, 0);
  endtask

  initial begin
    int pops, guard;
    bit bad;
    RST = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0;
    cmd_valid = 0; cmd_base = '0; cmd_len = '0; w_ready = 0;
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_last", w_last, 0);
    check("rst_cs", SRAM_CS, 0);
    check("rst_oe", SRAM_OE, 0);
    check("rst_web", SRAM_WEB, 1);
    check("rst_a", SRAM_A, 0);
    check("rst_di", SRAM_DI, 0);
    tick(); tick();
    RST = 1'b0;

    // Fill the whole array.
    for (int i = 0; i < 256; i++) begin
      wr_valid   = 1'b1;
      wr_addr    = 8'(i);
      wr_data    = 32'hA5A5_0000 + 32'(i);
      exp_mem[i] = 32'hA5A5_0000 + 32'(i);
      #1;
      check("wr_ready", wr_ready, 1);
      check("wr_web", SRAM_WEB, 0);
      tick();
    end
    wr_valid = 1'b0;

    // Full-array burst: last pop 258 cycles after accept.
    start_cmd(0, 256);
    collect(0, 256, 0, 258);

    // Address wrap 254, 255, 0, 1.
    start_cmd(254, 4);
    collect(254, 4, 0, 6);

    // Backpressure with w_ready toggling.
    start_cmd(16, 8);
    collect(16, 8, 1, -1);

    // Command wins over a same-cycle write; write refused while busy.
    wr_valid  = 1'b1;
    wr_addr   = 8'd40;
    wr_data   = 32'hDEAD_BEEF;
    cmd_base  = 8'd40;
    cmd_len   = 9'd2;
    cmd_valid = 1'b1;
    #1;
    check("prio_cmd_ready", cmd_ready, 1);
    check("prio_wr_ready", wr_ready, 0);
    check("prio_cs", SRAM_CS, 0);
    tick();
    cmd_valid = 1'b0;
    check("read_wr_ready", wr_ready, 0);
    check("read_web", SRAM_WEB, 1);
    check("read_busy", busy, 1);
    collect(40, 2, 0, 4);
    check("late_wr_ready", wr_ready, 1);
    check("late_wr_cs", SRAM_CS, 1);
    check("late_wr_web", SRAM_WEB, 0);
    check("late_wr_a", SRAM_A, 40);
    tick();
    wr_valid    = 1'b0;
    exp_mem[40] = 32'hDEAD_BEEF;
    start_cmd(40, 1);
    collect(40, 1, 0, 3);

    // Zero-length command: no access, no output, never busy.
    cmd_base  = 8'd5;
    cmd_len   = 9'd0;
    cmd_valid = 1'b1;
    #1;
    check("len0_cmd_ready", cmd_ready, 1);
    check("len0_cs", SRAM_CS, 0);
    tick();
    cmd_valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (SRAM_CS || w_valid || busy) bad = 1'b1;
      tick();
    end
    check("len0_quiet", bad, 0);

    // Reset after three words of a 16-word burst.
    start_cmd(0, 16);
    w_ready = 1'b1;
    pops = 0; guard = 0;
    while (pops < 3 && guard < 20) begin
      if (w_valid) pops++;
      tick();
      guard++;
    end
    check("pre_rst_pops", pops, 3);
    RST = 1'b1;
    #1;
    check("mid_rst_w_valid", w_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cs", SRAM_CS, 0);
    check("mid_rst_oe", SRAM_OE, 0);
    check("mid_rst_web", SRAM_WEB, 1);
    check("mid_rst_a", SRAM_A, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_w_data", w_data, 0);
    tick();
    check("held_rst_cs", SRAM_CS, 0);
    check("held_rst_w_valid", w_valid, 0);
    RST = 1'b0;
    tick();
    start_cmd(100, 5);
    collect(100, 5, 0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
